// File: rtl/pmp_check_ctrl.sv
// pmp_check_ctrl
//
// Shared, multi-cycle PMP check engine for the MMU/LSU boundary. Requesters
// are granted round-robin. The engine scans the PMP entry array one entry per
// cycle and stops at the lowest-numbered matching entry. The allow/deny result
// is registered and returned only to the requester that owns the check.
//
// The RISC-V types are carried here as plain vectors:
//   access (pmp_access_t) : [2]=X, [1]=W, [0]=R
//   priv   (priv_lvl_t)   : 2'b00=U, 2'b01=S, 2'b11=M
//   cfg    (pmpcfg_t)     : [7]=L, [6:5] reserved, [4:3] mode
//                           (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [2:0] access
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             abort any in-flight check; no response is produced
//   req_valid_i         per-requester request valid (0 = fetch, 1 = data)
//   req_addr_i          per-requester byte address
//   req_access_i        per-requester requested R/W/X bits
//   req_priv_i          per-requester privilege level
//   req_gnt_o           one-hot grant, combinational, only driven in IDLE
//   resp_valid_o        response valid for the owning requester
//   resp_allow_o        check result, qualified by resp_valid_o
//   resp_ready_i        per-requester response accept
//   conf_addr_i         pmpaddr array (addr[PMP_LEN+1:2] per entry)
//   conf_i              pmpcfg array
//   busy_o              high while a check is in SCAN or RESP

module pmp_check_ctrl #(
   parameter int PLEN       = 56,
   parameter int PMP_LEN    = 54,
   parameter int NR_ENTRIES = 16,
   parameter int NR_REQ     = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 flush_i,
   input  logic [NR_REQ-1:0]                    req_valid_i,
   input  logic [NR_REQ-1:0][PLEN-1:0]          req_addr_i,
   input  logic [NR_REQ-1:0][2:0]               req_access_i,
   input  logic [NR_REQ-1:0][1:0]               req_priv_i,
   output logic [NR_REQ-1:0]                    req_gnt_o,
   output logic [NR_REQ-1:0]                    resp_valid_o,
   output logic                                 resp_allow_o,
   input  logic [NR_REQ-1:0]                    resp_ready_i,
   input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
   input  logic [NR_ENTRIES-1:0][7:0]           conf_i,
   output logic                                 busy_o
);

   localparam int IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
   localparam int OWN_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_TOR   = 2'd1;
   localparam logic [1:0] MODE_NA4   = 2'd2;
   localparam logic [1:0] MODE_NAPOT = 2'd3;
   localparam logic [1:0] PRIV_M     = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [OWN_W-1:0]    rr_q, rr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [PLEN-1:0]     addr_q, addr_d;
   logic [2:0]          access_q, access_d;
   logic [1:0]          priv_q, priv_d;
   logic                result_q, result_d;

   logic [OWN_W-1:0]    gnt_idx;
   logic                gnt_found;
   logic                grant_en;
   int                  cand;

   logic [7:0]          cfg;
   logic [PMP_LEN-1:0]  cur_addr;
   logic [PMP_LEN-1:0]  prev_addr;
   logic [PMP_LEN-1:0]  word_addr;
   logic [PMP_LEN-1:0]  napot_mask;
   logic                entry_match;
   logic                hit_allow;
   logic                last_entry;
   logic                unused_bits;

   // Round-robin search starting at rr_q; the first valid requester wins.
   always_comb begin
      gnt_idx   = '0;
      gnt_found = 1'b0;
      cand      = 0;
      for (int i = 0; i < NR_REQ; i++) begin
         cand = int'(rr_q) + i;
         if (cand >= NR_REQ) begin
            cand = cand - NR_REQ;
         end
         if (!gnt_found && req_valid_i[OWN_W'(cand)]) begin
            gnt_found = 1'b1;
            gnt_idx   = OWN_W'(cand);
         end
      end
   end

   // A grant is only ever offered from IDLE and never in a flush cycle, so a
   // grant is also the handshake.
   assign grant_en = (state_q == IDLE) && !flush_i && gnt_found;

   always_comb begin
      req_gnt_o = '0;
      if (grant_en) begin
         req_gnt_o[gnt_idx] = 1'b1;
      end
   end

   // Entry evaluation for the current scan index. The TOR lower bound reads
   // entry idx-1, which is only meaningful for idx > 0.
   always_comb begin
      cfg        = conf_i[idx_q];
      cur_addr   = conf_addr_i[idx_q];
      prev_addr  = (idx_q == '0) ? '0 : conf_addr_i[idx_q - IDX_W'(1)];
      word_addr  = PMP_LEN'(addr_q[PLEN-1:2]);
      // x ^ (x+1) sets exactly the trailing-ones run plus the first zero above
      // it, i.e. bits [t:0]; an all-ones pmpaddr yields an all-ones mask.
      napot_mask = cur_addr ^ (cur_addr + PMP_LEN'(1));
      unique case (cfg[4:3])
         MODE_OFF:   entry_match = 1'b0;
         MODE_TOR:   entry_match = (word_addr >= prev_addr) && (word_addr < cur_addr);
         MODE_NA4:   entry_match = (word_addr == cur_addr);
         MODE_NAPOT: entry_match = ((word_addr ^ cur_addr) & ~napot_mask) == '0;
         default:    entry_match = 1'b0;
      endcase
      // Unlocked entries never restrict M-mode.
      if ((priv_q == PRIV_M) && !cfg[7]) begin
         hit_allow = 1'b1;
      end else begin
         hit_allow = (access_q & cfg[2:0]) == access_q;
      end
      last_entry = (idx_q == IDX_W'(NR_ENTRIES - 1));
   end

   assign unused_bits = ^{cfg[6:5], addr_q[1:0]};

   // Next-state and datapath update. flush_i overrides every state but leaves
   // the round-robin pointer untouched.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      idx_d    = idx_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      access_d = access_q;
      priv_d   = priv_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               state_d  = SCAN;
               idx_d    = '0;
               owner_d  = gnt_idx;
               addr_d   = req_addr_i[gnt_idx];
               access_d = req_access_i[gnt_idx];
               priv_d   = req_priv_i[gnt_idx];
               rr_d     = (gnt_idx == OWN_W'(NR_REQ - 1)) ? '0 : gnt_idx + OWN_W'(1);
            end
         end
         SCAN: begin
            if (entry_match) begin
               result_d = hit_allow;
               state_d  = RESP;
            end else if (last_entry) begin
               result_d = (priv_q == PRIV_M);
               state_d  = RESP;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         RESP: begin
            if (resp_ready_i[owner_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush_i) begin
         state_d = IDLE;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         idx_q    <= '0;
         owner_q  <= '0;
         addr_q   <= '0;
         access_q <= '0;
         priv_q   <= '0;
         result_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         idx_q    <= idx_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         access_q <= access_d;
         priv_q   <= priv_d;
         result_q <= result_d;
      end
   end

   // Response outputs come straight from registers; a flush suppresses them
   // in the same cycle so no response can be accepted while aborting.
   always_comb begin
      resp_valid_o = '0;
      if ((state_q == RESP) && !flush_i) begin
         resp_valid_o[owner_q] = 1'b1;
      end
      resp_allow_o = (state_q == RESP) && !flush_i && result_q;
      busy_o       = (state_q != IDLE);
   end

endmodule
